fmul_share_arbiter: RTL and testbench
=====================================

# fmul_share_arbiter

Shares one combinational `float_multiplier` instance (internal) among `NUM_REQ` requesters. Each requester presents an operand pair under a valid/ready handshake. A round-robin arbiter grants one requester at a time and latches its operands. The block returns the product, the IEEE-style overflow/underflow/inexact flags and the requester ID through a single response port with backpressure, and also keeps sticky exception flags for software status.

## Interface
- `FLOAT_SIZE`, 32: float bit-length.
- `EXPONENT_SIZE`, 8: exponent bit-length.
- `MANTISSA_SIZE`, 23: mantissa bit-length.
- `BIAS`, 127: exponent bias.
- `NUM_REQ`, 4: number of requesters, 2..16.
- `ID_SIZE`, derived `$clog2(NUM_REQ)`: requester ID width.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  per-requester operand valid.
- `req_a`  in  NUM_REQ*FLOAT_SIZE  operand A; requester i occupies bits [i*FLOAT_SIZE +: FLOAT_SIZE].
- `req_b`  in  NUM_REQ*FLOAT_SIZE  operand B; same packing.
- `req_ready`  out  NUM_REQ  one-hot accept; at most one bit set.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts result.
- `resp_id`  out  ID_SIZE  index of the requester that owns the result.
- `resp_out`  out  FLOAT_SIZE  product.
- `resp_overflow`, `resp_underflow`, `resp_inexact`  out  1 each  multiplier flags for this result.
- `sticky_flags`  out  3  {overflow, underflow, inexact}; each bit is the OR of that flag over all completed responses since the last clear.
- `clear_flags`  in  1  synchronous clear of `sticky_flags`.

## Operation
- FSM states: IDLE, CALC, RESP. Reset state is IDLE.
- IDLE:
  - `req_ready` is combinational. The bit is set for the winner only, and only in IDLE.
  - Winner = first i with `req_valid[i]=1`, scanning i = rr_ptr, rr_ptr+1, … and wrapping modulo NUM_REQ.
  - On the handshake (`req_valid[i] & req_ready[i]`): register a_i, b_i and id=i; set rr_ptr=(i+1) mod NUM_REQ; go to CALC.
  - If no requester is valid, stay in IDLE; rr_ptr is unchanged.
- CALC:
  - Latched operands drive the multiplier.
  - At the clock edge, capture out/overflow/underflow/inexact into the response registers; go to RESP.
- RESP:
  - `resp_valid`=1.
  - All resp_* outputs stay stable until `resp_ready`=1. Then go to IDLE.
- Sticky flags:
  - OR'd in on the response handshake (`resp_valid & resp_ready`).
  - If `clear_flags` and a handshake happen in the same cycle, clear wins; that handshake's flags are lost.
- Requesters must hold `req_valid` and their operands stable until accepted. The arbiter never drops a request; a request waits through NUM_REQ-1 other grants at most.
- Multiplier semantics are unchanged: normalized inputs only, truncation, no special-value handling. Flags are passed through unmodified.
- Ungranted requesters see `req_ready`=0, and their inputs are ignored.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0.
  - `resp_valid`=0.
  - `resp_id`, `resp_out` and the resp flags = 0.
  - `sticky_flags`=0.
  - `req_ready` = combinational winner. It may be non-zero during reset deassertion only if `req_valid` is set, and it is gated to 0 while `rst_n`=0.
- Latency: accept edge at cycle T → CALC in T+1 → `resp_valid`=1 in T+2.
- Throughput: with `resp_ready` tied high, one operation per 3 cycles; the next accept is possible in T+3.
- Backpressure: each cycle `resp_ready`=0 in RESP adds one cycle; no new accept occurs during that time.
- Reset mid-operation (CALC or RESP): the in-flight result is discarded; all outputs go to their reset values immediately (asynchronous).

## Test plan
- Single request, requester 2, a=0x40000000 (2.0), b=0x40400000 (3.0), `resp_ready`=1:
  - `req_ready`=4'b0100 in the accept cycle.
  - Two cycles later: `resp_valid`=1, `resp_id`=2, `resp_out`=0x40C00000, all flags 0.
- Normalization and inexact, requester 0:
  - 0x3FC00000 × 0x3FC00000 → 0x40100000, inexact=0.
  - 0x3F800001 × 0x3F800001 → 0x3F800002, inexact=1; `sticky_flags`=3'b001.
- Overflow and underflow:
  - 0x7F000000 × 0x7F000000 → overflow=1, underflow=0.
  - 0x00800000 × 0x00800000 → underflow=1, overflow=0.
  - After both: `sticky_flags`=3'b110 (3'b111 if the inexact case above already ran). After `clear_flags`: 3'b000.
- Round-robin fairness:
  - All four `req_valid` held high with `resp_ready`=1 → `resp_id` sequence 0,1,2,3,0,1.
  - Drop requester 1 after its first grant → sequence continues 2,3,0,2.
- Backpressure: hold `resp_ready`=0 for 5 cycles in RESP → `resp_valid`=1 and all resp_* outputs stable; `req_ready`=0 throughout. Release → IDLE on the next cycle.
- Reset in CALC: assert `rst_n`=0 → `resp_valid`=0 and `sticky_flags`=0 immediately. After release, the first grant goes to requester 0 if it is valid (rr_ptr=0).

Source files
------------

// File: rtl/fmul_share_arbiter_if.sv
// Request/response bundle for fmul_share_arbiter: NUM_REQ operand ports sharing
// one result port.
interface fmul_share_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FLOAT_SIZE = 32,
  parameter int ID_SIZE    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*FLOAT_SIZE-1:0] req_a;
  logic [NUM_REQ*FLOAT_SIZE-1:0] req_b;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          resp_valid;
  logic                          resp_ready;
  logic [ID_SIZE-1:0]            resp_id;
  logic [FLOAT_SIZE-1:0]         resp_out;
  logic                          resp_overflow;
  logic                          resp_underflow;
  logic                          resp_inexact;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_out,
           resp_overflow, resp_underflow, resp_inexact
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_out,
           resp_overflow, resp_underflow, resp_inexact
  );
endinterface

// File: rtl/fmul_share_arbiter.sv
// One combinational float multiplier shared round-robin among NUM_REQ requesters,
// with a backpressured response port and sticky exception flags.

module float_multiplier #(
  parameter int FLOAT_SIZE    = 32,
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23,
  parameter int BIAS          = 127
) (
  input  logic [FLOAT_SIZE-1:0] a,
  input  logic [FLOAT_SIZE-1:0] b,
  output logic [FLOAT_SIZE-1:0] out,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  inexact
);
  localparam int SW = MANTISSA_SIZE + 1;
  localparam int EW = EXPONENT_SIZE + 2;
  localparam logic signed [EW-1:0] BIAS_W  = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXPONENT_SIZE) - 1);
  localparam logic signed [EW-1:0] ONE_W   = EW'(1);

  logic                     sign;
  logic [SW-1:0]            sig_a;
  logic [SW-1:0]            sig_b;
  logic [2*SW-1:0]          prod;
  logic [MANTISSA_SIZE-1:0] mant;
  logic signed [EW-1:0]     exp_sum;
  logic signed [EW-1:0]     exp_r;

  always_comb begin
    sign    = a[FLOAT_SIZE-1] ^ b[FLOAT_SIZE-1];
    sig_a   = {1'b1, a[MANTISSA_SIZE-1:0]};
    sig_b   = {1'b1, b[MANTISSA_SIZE-1:0]};
    prod    = {{SW{1'b0}}, sig_a} * {{SW{1'b0}}, sig_b};
    exp_sum = $signed({2'b00, a[FLOAT_SIZE-2 -: EXPONENT_SIZE]})
            + $signed({2'b00, b[FLOAT_SIZE-2 -: EXPONENT_SIZE]})
            - BIAS_W;
    // Product of two 1.x significands lies in [1,4); renormalize by one bit if >= 2.
    if (prod[2*SW-1]) begin
      mant    = prod[2*SW-2 -: MANTISSA_SIZE];
      inexact = |prod[MANTISSA_SIZE:0];
      exp_r   = exp_sum + ONE_W;
    end else begin
      mant    = prod[2*SW-3 -: MANTISSA_SIZE];
      inexact = |prod[MANTISSA_SIZE-1:0];
      exp_r   = exp_sum;
    end
    underflow = exp_r[EW-1] || (exp_r == '0);
    overflow  = !exp_r[EW-1] && (exp_r >= EXP_MAX);
    if (overflow) begin
      out = {sign, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
    end else if (underflow) begin
      out = {sign, {(FLOAT_SIZE-1){1'b0}}};
    end else begin
      out = {sign, exp_r[EXPONENT_SIZE-1:0], mant};
    end
  end
endmodule

// state | meaning
// ------+----------------------------------------------------------
// IDLE  | arbitrate; grant the round-robin winner and latch operands
// CALC  | latched operands through the multiplier; capture the result
// RESP  | hold result on the response port until resp_ready
module fmul_share_arbiter #(
  parameter int FLOAT_SIZE    = 32,
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23,
  parameter int BIAS          = 127,
  parameter int NUM_REQ       = 4,
  localparam int ID_SIZE      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fmul_share_arbiter_if.slave  bus,
  input  logic                 clear_flags,
  output logic [2:0]           sticky_flags
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ID_SIZE-1:0]      rr_ptr_q, rr_ptr_d;
  logic [FLOAT_SIZE-1:0]   op_a_q, op_a_d;
  logic [FLOAT_SIZE-1:0]   op_b_q, op_b_d;
  logic [ID_SIZE-1:0]      op_id_q, op_id_d;
  logic [ID_SIZE-1:0]      resp_id_q, resp_id_d;
  logic [FLOAT_SIZE-1:0]   resp_out_q, resp_out_d;
  logic                    resp_ovf_q, resp_ovf_d;
  logic                    resp_unf_q, resp_unf_d;
  logic                    resp_inx_q, resp_inx_d;
  logic [2:0]              sticky_q, sticky_d;

  logic                    win_found;
  logic [ID_SIZE-1:0]      win_id;
  logic [NUM_REQ-1:0]      req_ready_c;
  logic                    resp_hs;
  logic [FLOAT_SIZE-1:0]   mul_out;
  logic                    mul_ovf;
  logic                    mul_unf;
  logic                    mul_inx;

  function automatic logic [ID_SIZE-1:0] scan_idx(input logic [ID_SIZE-1:0] base,
                                                  input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_SIZE'(s);
  endfunction

  float_multiplier #(
    .FLOAT_SIZE    (FLOAT_SIZE),
    .EXPONENT_SIZE (EXPONENT_SIZE),
    .MANTISSA_SIZE (MANTISSA_SIZE),
    .BIAS          (BIAS)
  ) u_mul (
    .a         (op_a_q),
    .b         (op_b_q),
    .out       (mul_out),
    .overflow  (mul_ovf),
    .underflow (mul_unf),
    .inexact   (mul_inx)
  );

  // First valid requester scanning upward from rr_ptr with wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && bus.req_valid[scan_idx(rr_ptr_q, k)]) begin
        win_found = 1'b1;
        win_id    = scan_idx(rr_ptr_q, k);
      end
    end
  end

  assign resp_hs = (state_q == ST_RESP) && bus.resp_ready;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_id_d     = op_id_q;
    resp_id_d   = resp_id_q;
    resp_out_d  = resp_out_q;
    resp_ovf_d  = resp_ovf_q;
    resp_unf_d  = resp_unf_q;
    resp_inx_d  = resp_inx_q;
    sticky_d    = sticky_q;
    req_ready_c = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          req_ready_c = NUM_REQ'(1) << win_id;
          op_a_d      = bus.req_a[win_id*FLOAT_SIZE +: FLOAT_SIZE];
          op_b_d      = bus.req_b[win_id*FLOAT_SIZE +: FLOAT_SIZE];
          op_id_d     = win_id;
          rr_ptr_d    = (win_id == ID_SIZE'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
          state_d     = ST_CALC;
        end
      end
      ST_CALC: begin
        resp_id_d  = op_id_q;
        resp_out_d = mul_out;
        resp_ovf_d = mul_ovf;
        resp_unf_d = mul_unf;
        resp_inx_d = mul_inx;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A clear in the same cycle as a handshake drops that response's flags.
    if (clear_flags) begin
      sticky_d = '0;
    end else if (resp_hs) begin
      sticky_d = sticky_q | {resp_ovf_q, resp_unf_q, resp_inx_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_id_q    <= '0;
      resp_id_q  <= '0;
      resp_out_q <= '0;
      resp_ovf_q <= 1'b0;
      resp_unf_q <= 1'b0;
      resp_inx_q <= 1'b0;
      sticky_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_id_q    <= op_id_d;
      resp_id_q  <= resp_id_d;
      resp_out_q <= resp_out_d;
      resp_ovf_q <= resp_ovf_d;
      resp_unf_q <= resp_unf_d;
      resp_inx_q <= resp_inx_d;
      sticky_q   <= sticky_d;
    end
  end

  assign bus.req_ready      = rst_n ? req_ready_c : '0;
  assign bus.resp_valid     = (state_q == ST_RESP);
  assign bus.resp_id        = resp_id_q;
  assign bus.resp_out       = resp_out_q;
  assign bus.resp_overflow  = resp_ovf_q;
  assign bus.resp_underflow = resp_unf_q;
  assign bus.resp_inexact   = resp_inx_q;
  assign sticky_flags       = sticky_q;
endmodule

// File: tb/tb_fmul_share_arbiter.sv
// Directed bench for fmul_share_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_fmul_share_arbiter;
  localparam int NR = 4;
  localparam int FS = 32;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] out;
    logic [2:0]  f;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear_flags = 1'b0;
  logic [2:0] sticky_flags;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] t_a [NR];
  logic [31:0] t_b [NR];
  logic [31:0] t_o [NR];
  logic [2:0]  t_f [NR];

  always #5 clk = ~clk;

  fmul_share_arbiter_if #(.NUM_REQ(NR), .FLOAT_SIZE(FS)) bus ();

  fmul_share_arbiter #(.NUM_REQ(NR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .clear_flags  (clear_flags),
    .sticky_flags (sticky_flags)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual_id=%0d required=none", bus.resp_id);
      end else begin
        e = sb.pop_front();
        chk("resp_id", 64'(bus.resp_id), 64'(e.id));
        chk("resp_out", 64'(bus.resp_out), 64'(e.out));
        chk("resp_flags", 64'({bus.resp_overflow, bus.resp_underflow, bus.resp_inexact}), 64'(e.f));
      end
    end
  end

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[id*FS +: FS] = a;
    bus.req_b[id*FS +: FS] = b;
    bus.req_valid[id]      = 1'b1;
  endtask

  task automatic push_exp(input int id, input logic [31:0] o, input logic [2:0] f);
    exp_t e;
    e.id  = 2'(id);
    e.out = o;
    e.f   = f;
    sb.push_back(e);
  endtask

  task automatic wait_grant(input int exp_id);
    int n = 0;
    #1;
    while (bus.req_ready == '0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_grant", 64'(bus.req_ready), 64'(4'b0001 << exp_id));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual_pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic single(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] o, input logic [2:0] f);
    set_req(id, a, b);
    wait_grant(id);
    push_exp(id, o, f);
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
    chk("calc_resp_valid", 64'(bus.resp_valid), 64'd0);
    @(posedge clk); #1;
    chk("latency_resp_valid", 64'(bus.resp_valid), 64'd1);
    drain();
  endtask

  initial begin
    int seq_a[6] = '{0, 1, 2, 3, 0, 1};
    int seq_b[6] = '{0, 2'd1, 2, 3, 0, 2};

    t_a[0] = 32'h40000000; t_b[0] = 32'h40400000; t_o[0] = 32'h40C00000; t_f[0] = 3'b000;
    t_a[1] = 32'h3FC00000; t_b[1] = 32'h3FC00000; t_o[1] = 32'h40100000; t_f[1] = 3'b000;
    t_a[2] = 32'h3F800001; t_b[2] = 32'h3F800001; t_o[2] = 32'h3F800002; t_f[2] = 3'b001;
    t_a[3] = 32'h40000000; t_b[3] = 32'hBFC00000; t_o[3] = 32'hC0400000; t_f[3] = 3'b000;

    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;

    // Reset values, and req_ready gated while in reset
    repeat (2) @(posedge clk);
    bus.req_valid[0] = 1'b1;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_id", 64'(bus.resp_id), 64'd0);
    chk("rst_resp_out", 64'(bus.resp_out), 64'd0);
    chk("rst_resp_flags", 64'({bus.resp_overflow, bus.resp_underflow, bus.resp_inexact}), 64'd0);
    chk("rst_sticky", 64'(sticky_flags), 64'd0);
    bus.req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_req_ready", 64'(bus.req_ready), 64'd0);

    single(2, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000);
    single(0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000);
    single(0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b001);
    chk("sticky_inexact", 64'(sticky_flags), 64'b001);
    single(0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100);
    single(0, 32'h00800000, 32'h00800000, 32'h00000000, 3'b010);
    chk("sticky_all", 64'(sticky_flags), 64'b111);
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    chk("sticky_cleared", 64'(sticky_flags), 64'b000);

    // Backpressure on an inexact result, then clear coinciding with its handshake
    bus.resp_ready = 1'b0;
    set_req(2, t_a[2], t_b[2]);
    wait_grant(2);
    push_exp(2, t_o[2], t_f[2]);
    @(posedge clk); #1;
    bus.req_valid[2] = 1'b0;
    set_req(3, t_a[3], t_b[3]);
    chk("calc_req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("bp_resp_id", 64'(bus.resp_id), 64'd2);
      chk("bp_resp_out", 64'(bus.resp_out), 64'h3F800002);
      chk("bp_resp_flags", 64'({bus.resp_overflow, bus.resp_underflow, bus.resp_inexact}), 64'b001);
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    clear_flags    = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    chk("clear_wins", 64'(sticky_flags), 64'b000);
    chk("idle_after_release", 64'(bus.req_ready), 64'b1000);
    push_exp(3, t_o[3], t_f[3]);
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    drain();

    // Round robin with all requesters held valid
    for (int i = 0; i < NR; i++) set_req(i, t_a[i], t_b[i]);
    for (int k = 0; k < 6; k++) begin
      wait_grant(seq_a[k]);
      push_exp(seq_a[k], t_o[seq_a[k]], t_f[seq_a[k]]);
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    drain();
    chk("sticky_after_rr", 64'(sticky_flags), 64'b001);

    // Reset while in CALC
    set_req(3, t_a[3], t_b[3]);
    wait_grant(3);
    push_exp(3, t_o[3], t_f[3]);
    @(posedge clk); #1;
    set_req(0, t_a[0], t_b[0]);
    rst_n = 1'b0;
    #1;
    chk("rst_calc_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_calc_sticky", 64'(sticky_flags), 64'd0);
    chk("rst_calc_req_ready", 64'(bus.req_ready), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_grant", 64'(bus.req_ready), 64'b0001);

    // Round robin from pointer 0, requester 1 leaves after its first grant
    for (int i = 0; i < NR; i++) set_req(i, t_a[i], t_b[i]);
    for (int k = 0; k < 6; k++) begin
      wait_grant(seq_b[k]);
      push_exp(seq_b[k], t_o[seq_b[k]], t_f[seq_b[k]]);
      @(posedge clk); #1;
      if (k == 1) bus.req_valid[1] = 1'b0;
    end
    bus.req_valid = '0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
